data_mem_ctrl: RTL and testbench

Multicycle sequencer between the processor control unit's memory stage and the synchronous data RAM. Accepts one load or store request at a time over a ready/req handshake and range-checks the address against the data region. Drives the RAM's chip select, read/write strobes, address and write data, captures the registered read data, and returns a one-cycle `done` pulse with read data or an error flag.

---
 rtl/data_mem_ctrl_pkg.sv | 24 ++
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared widths, state encoding and the address range helper for the data memory sequencer.
package data_mem_ctrl_pkg;

    localparam int ADDRESS_BUS_WIDTH = 32;
    localparam int DATA_BUS_WIDTH    = 32;
    localparam int NUM_ADDRESSES     = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Subtraction wraps at full width, so an address below the base fails the first term.
    function automatic logic addr_in_range(
        input logic [ADDRESS_BUS_WIDTH-1:0] a,
        input logic [ADDRESS_BUS_WIDTH-1:0] base,
        input logic [ADDRESS_BUS_WIDTH-1:0] num
    );
        return (a >= base) && ((a - base) < num);
    endfunction

endpackage

// File: rtl/data_mem_ctrl.sv
// Multicycle load/store sequencer in front of the synchronous data RAM.
// All outputs are registered, decoded one cycle ahead from the next state.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter logic [ADDRESS_BUS_WIDTH-1:0] DATA_BASE          = {ADDRESS_BUS_WIDTH{1'b0}},
    parameter int unsigned                  NUM_DATA_ADDRESSES = NUM_ADDRESSES / 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] addr,
    input  logic [DATA_BUS_WIDTH-1:0]    wdata,
    output logic                         ready,
    output logic                         done,
    output logic                         err,
    output logic [DATA_BUS_WIDTH-1:0]    rdata,
    output logic [ADDRESS_BUS_WIDTH-1:0] memAddress,
    output logic                         memRead,
    output logic                         memWrite,
    output logic [DATA_BUS_WIDTH-1:0]    memWriteData,
    input  logic [DATA_BUS_WIDTH-1:0]    memReadData,
    output logic                         memCs
);

    state_e                         r_state;
    state_e                         w_next_state;
    logic                           w_accept;
    logic                           w_in_range;
    logic                           w_next_we;
    logic                           w_next_err;
    logic                           r_we;
    logic                           r_err_pend;
    logic                           r_ready;
    logic                           r_done;
    logic                           r_err;
    logic                           r_mem_cs;
    logic                           r_mem_read;
    logic                           r_mem_write;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_mem_addr;
    logic [DATA_BUS_WIDTH-1:0]      r_mem_wdata;
    logic [DATA_BUS_WIDTH-1:0]      r_rdata;

    assign w_in_range = addr_in_range(addr, DATA_BASE, ADDRESS_BUS_WIDTH'(NUM_DATA_ADDRESSES));

    // Next-state logic plus the transaction attributes the next state will act on
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_next_we    = r_we;
        w_next_err   = r_err_pend;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept     = 1'b1;
                    w_next_we    = we;
                    w_next_err   = !w_in_range;
                    w_next_state = w_in_range ? ST_ISSUE : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE:   w_next_state = r_we ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Moore outputs registered from the upcoming state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_ready     <= (w_next_state == ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
            r_err       <= (w_next_state == ST_DONE) && w_next_err;
            r_mem_cs    <= (w_next_state == ST_ISSUE);
            r_mem_read  <= (w_next_state == ST_ISSUE) && !w_next_we;
            r_mem_write <= (w_next_state == ST_ISSUE) && w_next_we;
        end
    end

    // Request latch; an out-of-range request leaves the RAM-facing registers untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_err_pend  <= 1'b0;
            r_mem_addr  <= {ADDRESS_BUS_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_BUS_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_we       <= we;
            r_err_pend <= !w_in_range;
            if (w_in_range) begin
                r_mem_addr  <= addr - DATA_BASE;
                r_mem_wdata <= wdata;
            end
        end
    end

    // Read data is valid from the RAM only during CAPTURE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= {DATA_BUS_WIDTH{1'b0}};
        end else if (r_state == ST_CAPTURE) begin
            r_rdata <= memReadData;
        end
    end

    assign ready        = r_ready;
    assign done         = r_done;
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign memCs        = r_mem_cs;
    assign memRead      = r_mem_read;
    assign memWrite     = r_mem_write;
    assign memAddress   = r_mem_addr;
    assign memWriteData = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl with a behavioural RAM and reference model.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'd0;
    localparam int          NROW = NUM_ADDRESSES / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] memAddress;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memCs;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram [0:NROW-1];
    logic [31:0] ram_q;
    logic        cs_d;

    logic [31:0] ref_mem [0:NROW-1];
    logic [31:0] exp_rdata;

    data_mem_ctrl #(.DATA_BASE(BASE), .NUM_DATA_ADDRESSES(NROW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .memAddress(memAddress), .memRead(memRead), .memWrite(memWrite),
        .memWriteData(memWriteData), .memReadData(memReadData), .memCs(memCs)
    );

    always #5 clk = ~clk;

    // Synchronous data RAM; output is junk unless chip select was high on the previous edge
    always @(posedge clk) begin
        cs_d <= memCs;
        if (memCs && memAddress < NROW) begin
            if (memWrite) ram[memAddress[6:0]] <= memWriteData;
            if (memRead)  ram_q <= ram[memAddress[6:0]];
        end
    end
    assign memReadData = cs_d ? ram_q : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {31'b0, ready}, 32'd1);
    endtask

    // One transaction, checked against the reference model's view of the outcome
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata);
        int dc = 0, cs_n = 0, rd_n = 0, wr_n = 0, both_n = 0, cs_at = 0, busy_rdy = 0;
        logic [31:0] ma = 32'd0, mwd = 32'd0, row;
        logic e = 1'b0, in_r;
        logic [31:0] got_rdata = 32'd0;
        in_r = (t_addr >= BASE) && ((t_addr - BASE) < NROW);
        row  = t_addr - BASE;
        wait_ready();
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (memCs) begin cs_n++; cs_at = c; ma = memAddress; mwd = memWriteData; end
            if (memRead) rd_n++;
            if (memWrite) wr_n++;
            if (memRead && memWrite) both_n++;
            if (ready) busy_rdy++;
            if (done) begin dc = c; e = err; got_rdata = rdata; break; end
        end
        if (in_r && t_we) ref_mem[row[6:0]] = t_wdata;
        if (in_r && !t_we) exp_rdata = ref_mem[row[6:0]];
        chk("done_cycle", dc, !in_r ? 32'd1 : (t_we ? 32'd2 : 32'd3));
        chk("err", {31'b0, e}, {31'b0, !in_r});
        chk("rdata", got_rdata, exp_rdata);
        chk("cs_count", cs_n, in_r ? 32'd1 : 32'd0);
        chk("rd_count", rd_n, (in_r && !t_we) ? 32'd1 : 32'd0);
        chk("wr_count", wr_n, (in_r && t_we) ? 32'd1 : 32'd0);
        chk("rd_wr_overlap", both_n, 32'd0);
        chk("ready_busy", busy_rdy, 32'd0);
        if (in_r) begin
            chk("cs_cycle", cs_at, 32'd1);
            chk("mem_addr", ma, row);
            chk("mem_wdata", mwd, t_wdata);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] done_pat, rdy_pat, a, r;
        for (int i = 0; i < NROW; i++) begin
            ram[i]     = i;
            ref_mem[i] = i;
        end
        exp_rdata = 32'd0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", {29'b0, memCs, memRead, memWrite}, 32'd0);
        chk("rst_maddr", memAddress, 32'd0);
        chk("rst_mwdata", memWriteData, 32'd0);

        run_txn(1'b0, 32'd49, 32'd0);
        run_txn(1'b1, 32'd7, 32'hDEAD_BEEF);
        run_txn(1'b0, 32'd7, 32'd0);
        run_txn(1'b0, BASE + NROW, 32'd0);
        run_txn(1'b1, 32'hFFFF_FFFF, 32'h1234_5678);

        // Held request: accepts at cycles 0 and 4, dropped before the next IDLE
        wait_ready();
        req = 1'b1; we = 1'b0; addr = 32'd3;
        done_pat = 32'd0; rdy_pat = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            done_pat[c] = done;
            rdy_pat[c]  = ready;
            if (c == 7) req = 1'b0;
        end
        exp_rdata = ref_mem[3];
        chk("hold_done_pat", done_pat, 32'h0000_0088);
        chk("hold_ready_pat", rdy_pat, 32'h0000_1F10);
        chk("hold_rdata", rdata, exp_rdata);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = NROW + $urandom_range(0, 127);
            else if (r == 1) a = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else if (r < 6)  a = $urandom_range(0, 15);
            else             a = $urandom_range(0, NROW - 1);
            run_txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset during CAPTURE of a load of 12
        run_txn(1'b0, 32'd20, 32'd0);
        wait_ready();
        req = 1'b1; we = 1'b0; addr = 32'd12;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_rdata = 32'd0;
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_ready", {31'b0, ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_done", {31'b0, done}, 32'd0);
        chk("rst_rel_ready", {31'b0, ready}, 32'd1);
        chk("rst_rel_rdata", rdata, 32'd0);
        run_txn(1'b0, 32'd12, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
